versatile_mem_ctrl_sched: RTL and testbench



---
 rtl/versatile_mem_ctrl_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_versatile_mem_ctrl_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/versatile_mem_ctrl_sched.sv
// versatile_mem_ctrl_sched
// SDRAM-clock-domain scheduler for the multi-port wishbone FIFO bridge.
// It picks an egress FIFO round-robin and pops one address/control word,
// which it turns into a single burst command for the SDRAM sequencer. For a
// write it then streams the egress data words to the sequencer. For a read
// it routes the sequencer's read beats into the owning port's ingress FIFO.
//
// Ports:
//   sdram_clk, sdram_rst  clock, synchronous active-high reset
//   fifo_empty[p]         egress FIFO p empty
//   fifo_rd[p]            one-hot egress pop; fifo_dat_i is valid the next cycle
//   fifo_dat_i            egress word: address {adr[35:6], we[5], bte[4:3], cti[2:0]}
//                         or data {dat[35:4], sel[3:0]}
//   ingress_wr[p]         one-hot ingress push, same cycle as rdat_valid
//   cmd_*                 burst command to the sequencer (valid/ready handshake)
//   wdat_*                write beat to the sequencer (valid/ready handshake)
//   rdat_valid            read beat strobe from the sequencer
//   busy                  high whenever the FSM is not in IDLE
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | arbitrate among non-empty egress FIFOs
// POP_ADR  | pop the address/control word of the granted port
// ADR_WAIT | capture the address word, decode burst length
// CMD      | present command until the sequencer accepts it
// WR_POP   | pop the next data word (waits while the FIFO is empty)
// WR_WAIT  | capture the data word
// WR_HOLD  | present write beat until the sequencer takes it
// RD_DATA  | forward read beats into the ingress FIFO
// DONE     | burst finished; advance the round-robin pointer

module versatile_mem_ctrl_sched #(
    parameter int nr_of_wb_ports = 3
) (
    input  logic                      sdram_clk,
    input  logic                      sdram_rst,
    input  logic [0:nr_of_wb_ports-1] fifo_empty,
    output logic [0:nr_of_wb_ports-1] fifo_rd,
    input  logic [35:0]               fifo_dat_i,
    output logic [0:nr_of_wb_ports-1] ingress_wr,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_we,
    output logic [29:0]               cmd_adr,
    output logic [4:0]                cmd_len,
    output logic [1:0]                cmd_bte,
    output logic                      wdat_valid,
    input  logic                      wdat_ready,
    output logic [31:0]               wdat,
    output logic [3:0]                wdat_sel,
    input  logic                      rdat_valid,
    output logic                      busy
);

    localparam int NP = nr_of_wb_ports;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [3:0] {
        IDLE,
        POP_ADR,
        ADR_WAIT,
        CMD,
        WR_POP,
        WR_WAIT,
        WR_HOLD,
        RD_DATA,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   port_q, port_d;
    logic [PW-1:0]   last_q, last_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            cmd_we_q, cmd_we_d;
    logic [29:0]     cmd_adr_q, cmd_adr_d;
    logic [1:0]      cmd_bte_q, cmd_bte_d;
    logic [4:0]      cmd_len_q, cmd_len_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [3:0]      wdat_sel_q, wdat_sel_d;

    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;

    // Single accesses (classic cycle or end-of-burst CTI) and linear BTE
    // collapse to one beat; otherwise BTE selects the wrap length.
    function automatic logic [4:0] burst_len(input logic [1:0] bte, input logic [2:0] cti);
        logic [4:0] len;
        if (cti == 3'b000 || cti == 3'b111 || bte == 2'b00) begin
            len = 5'd1;
        end else if (bte == 2'b01) begin
            len = 5'd4;
        end else if (bte == 2'b10) begin
            len = 5'd8;
        end else begin
            len = 5'd16;
        end
        return len;
    endfunction

    // Search starts one past the last completed grant so every port gets a
    // turn; the first non-empty candidate wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NP; i++) begin
            cand = PW'((int'(last_q) + i) % NP);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        cmd_we_d   = cmd_we_q;
        cmd_adr_d  = cmd_adr_q;
        cmd_bte_d  = cmd_bte_q;
        cmd_len_d  = cmd_len_q;
        wdat_d     = wdat_q;
        wdat_sel_d = wdat_sel_q;
        fifo_rd    = '0;
        ingress_wr = '0;
        cmd_valid  = 1'b0;
        wdat_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    port_d  = grant_idx;
                    state_d = POP_ADR;
                end
            end
            POP_ADR: begin
                fifo_rd[port_q] = 1'b1;
                state_d         = ADR_WAIT;
            end
            ADR_WAIT: begin
                cmd_adr_d = fifo_dat_i[35:6];
                cmd_we_d  = fifo_dat_i[5];
                cmd_bte_d = fifo_dat_i[4:3];
                cmd_len_d = burst_len(fifo_dat_i[4:3], fifo_dat_i[2:0]);
                cnt_d     = burst_len(fifo_dat_i[4:3], fifo_dat_i[2:0]);
                state_d   = CMD;
            end
            CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_d = cmd_we_q ? WR_POP : RD_DATA;
                end
            end
            WR_POP: begin
                if (!fifo_empty[port_q]) begin
                    fifo_rd[port_q] = 1'b1;
                    state_d         = WR_WAIT;
                end
            end
            WR_WAIT: begin
                wdat_d     = fifo_dat_i[35:4];
                wdat_sel_d = fifo_dat_i[3:0];
                state_d    = WR_HOLD;
            end
            WR_HOLD: begin
                wdat_valid = 1'b1;
                if (wdat_ready) begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = (cnt_q == 5'd1) ? DONE : WR_POP;
                end
            end
            RD_DATA: begin
                if (rdat_valid) begin
                    ingress_wr[port_q] = 1'b1;
                    cnt_d              = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = port_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are suppressed in the reset cycle itself so an abort never
        // leaks a pop or push into the FIFOs being reset alongside us.
        if (sdram_rst) begin
            fifo_rd    = '0;
            ingress_wr = '0;
            cmd_valid  = 1'b0;
            wdat_valid = 1'b0;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q    <= IDLE;
            port_q     <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            cmd_we_q   <= 1'b0;
            cmd_adr_q  <= '0;
            cmd_bte_q  <= '0;
            cmd_len_q  <= '0;
            wdat_q     <= '0;
            wdat_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            cmd_we_q   <= cmd_we_d;
            cmd_adr_q  <= cmd_adr_d;
            cmd_bte_q  <= cmd_bte_d;
            cmd_len_q  <= cmd_len_d;
            wdat_q     <= wdat_d;
            wdat_sel_q <= wdat_sel_d;
        end
    end

    assign cmd_we   = cmd_we_q;
    assign cmd_adr  = cmd_adr_q;
    assign cmd_bte  = cmd_bte_q;
    assign cmd_len  = cmd_len_q;
    assign wdat     = wdat_q;
    assign wdat_sel = wdat_sel_q;
    assign busy     = !sdram_rst && (state_q != IDLE);

endmodule

// File: tb/tb_versatile_mem_ctrl_sched.sv
module tb_versatile_mem_ctrl_sched;

    logic        sdram_clk;
    logic        sdram_rst;
    logic [0:2]  fifo_empty;
    logic [0:2]  fifo_rd;
    logic [35:0] fifo_dat_i;
    logic [0:2]  ingress_wr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [29:0] cmd_adr;
    logic [4:0]  cmd_len;
    logic [1:0]  cmd_bte;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic [3:0]  wdat_sel;
    logic        rdat_valid;
    logic        busy;

    versatile_mem_ctrl_sched #(.nr_of_wb_ports(3)) dut (
        .sdram_clk  (sdram_clk),
        .sdram_rst  (sdram_rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dat_i (fifo_dat_i),
        .ingress_wr (ingress_wr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .cmd_bte    (cmd_bte),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .wdat_sel   (wdat_sel),
        .rdat_valid (rdat_valid),
        .busy       (busy)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        int          port;
        logic        we;
        logic [29:0] adr;
        logic [1:0]  bte;
        logic [2:0]  cti;
        int          len;
        int          dly;
        logic        stall;
        logic [31:0] d0;
    } vec_t;

    vec_t vecs[8];

    // egress FIFO models and scoreboards
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] q2[$];
    logic [0:2]  exp_rd[$];
    logic [37:0] exp_cmd[$];
    logic [35:0] exp_wdat[$];
    logic [0:2]  exp_ing[$];

    logic [0:2]  force_empty;
    logic [0:2]  pop_req;
    int          n_vec;
    int          n_err;
    int          pops_seen;
    int          beats_seen;
    int          ing_seen;

    function automatic logic [0:2] oh(input int p);
        logic [0:2] r;
        r = 3'b100 >> p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty[0] = force_empty[0] || (q0.size() == 0);
        fifo_empty[1] = force_empty[1] || (q1.size() == 0);
        fifo_empty[2] = force_empty[2] || (q2.size() == 0);
    endtask

    task automatic push_port(input int p, input logic [35:0] w);
        case (p)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    // One clock: sample/score at negedge, then advance past posedge and
    // model the egress RAM (data appears the cycle after the pop).
    task automatic cyc();
        logic [0:2]  e3;
        logic [37:0] ec;
        logic [35:0] ew;
        @(negedge sdram_clk);
        pop_req = fifo_rd;
        if (|fifo_rd) begin
            pops_seen++;
            if (!$onehot(fifo_rd) || ((fifo_rd & fifo_empty) != 3'b000)) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_legal: fifo_rd=%b fifo_empty=%b", fifo_rd, fifo_empty);
            end
            if (exp_rd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: fifo_rd=%b none expected", fifo_rd);
            end else begin
                e3 = exp_rd.pop_front();
                chk("fifo_rd", 64'(fifo_rd), 64'(e3));
            end
        end
        if (cmd_valid && cmd_ready) begin
            if (exp_cmd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cmd_unexpected: adr=%h none expected", cmd_adr);
            end else begin
                ec = exp_cmd.pop_front();
                chk("cmd", 64'({cmd_we, cmd_adr, cmd_len, cmd_bte}), 64'(ec));
            end
        end
        if (wdat_valid && wdat_ready) begin
            beats_seen++;
            if (exp_wdat.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wdat_unexpected: wdat=%h none expected", wdat);
            end else begin
                ew = exp_wdat.pop_front();
                chk("wdat", 64'({wdat, wdat_sel}), 64'(ew));
            end
        end
        if (|ingress_wr) begin
            ing_seen++;
            if (exp_ing.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ingress_unexpected: ingress_wr=%b none expected", ingress_wr);
            end else begin
                e3 = exp_ing.pop_front();
                chk("ingress_wr", 64'(ingress_wr), 64'(e3));
            end
        end
        @(posedge sdram_clk);
        #1;
        if (pop_req[0] && q0.size() > 0) fifo_dat_i = q0.pop_front();
        if (pop_req[1] && q1.size() > 0) fifo_dat_i = q1.pop_front();
        if (pop_req[2] && q2.size() > 0) fifo_dat_i = q2.pop_front();
        refresh();
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        while (!cmd_valid && n < 30) begin
            cyc();
            n++;
        end
        if (!cmd_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_timeout: cmd_valid=%b after %0d cycles", cmd_valid, n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            cyc();
            n++;
        end
        chk("idle_after", 64'(busy), 64'(0));
    endtask

    task automatic check_drained();
        chk("exp_rd_left", 64'(exp_rd.size()), 64'(0));
        chk("exp_cmd_left", 64'(exp_cmd.size()), 64'(0));
        chk("exp_wdat_left", 64'(exp_wdat.size()), 64'(0));
        chk("exp_ing_left", 64'(exp_ing.size()), 64'(0));
    endtask

    // queue the address word (+ data words for writes) and all expectations
    task automatic load_txn(input vec_t v);
        push_port(v.port, {v.adr, v.we, v.bte, v.cti});
        exp_rd.push_back(oh(v.port));
        exp_cmd.push_back({v.we, v.adr, 5'(v.len), v.bte});
        for (int b = 0; b < v.len; b++) begin
            if (v.we) begin
                push_port(v.port, {v.d0 + 32'(b), 4'hF ^ 4'(b)});
                exp_rd.push_back(oh(v.port));
                exp_wdat.push_back({v.d0 + 32'(b), 4'hF ^ 4'(b)});
            end else begin
                exp_ing.push_back(oh(v.port));
            end
        end
        refresh();
    endtask

    task automatic run_txn(input vec_t v);
        load_txn(v);
        wait_cmd();
        for (int d = 0; d < v.dly; d++) begin
            chk("cmd_hold", 64'({cmd_valid, cmd_we, cmd_adr, cmd_len, cmd_bte}),
                64'({1'b1, v.we, v.adr, 5'(v.len), v.bte}));
            cyc();
        end
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
        if (v.we) begin
            for (int n = 0; n < 400 && busy; n++) begin
                wdat_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc();
            end
            wdat_ready = 1'b0;
        end else begin
            for (int b = 0; b < v.len; b++) begin
                rdat_valid = 1'b1;
                cyc();
                rdat_valid = 1'b0;
                if (b % 3 == 1) cyc();
            end
        end
        wait_idle();
        check_drained();
    endtask

    initial begin
        vec_t v;
        int   base;
        int   hold;
        logic forced;

        n_vec = 0;
        n_err = 0;
        pops_seen = 0;
        beats_seen = 0;
        ing_seen = 0;
        sdram_rst = 1'b1;
        cmd_ready = 1'b0;
        wdat_ready = 1'b0;
        rdat_valid = 1'b0;
        fifo_dat_i = '0;
        force_empty = '0;
        pop_req = '0;
        refresh();

        //        port we adr             bte    cti   len dly stall d0
        vecs[0] = '{1, 1'b1, 30'h100,      2'b00, 3'b000, 1, 0, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{0, 1'b0, 30'h200,      2'b10, 3'b010, 8, 3, 1'b0, 32'h0};
        vecs[2] = '{2, 1'b0, 30'h0abc,     2'b01, 3'b010, 4, 1, 1'b0, 32'h0};
        vecs[3] = '{1, 1'b1, 30'h3ff0000,  2'b11, 3'b010, 16, 0, 1'b1, 32'h12345678};
        vecs[4] = '{0, 1'b0, 30'h55,       2'b11, 3'b111, 1, 2, 1'b0, 32'h0};
        vecs[5] = '{2, 1'b1, 30'h1234,     2'b01, 3'b000, 1, 0, 1'b1, 32'hCAFEF00D};
        vecs[6] = '{0, 1'b1, 30'h2a,       2'b00, 3'b010, 1, 0, 1'b0, 32'h0BADC0DE};
        vecs[7] = '{1, 1'b0, 30'h3fffffff, 2'b10, 3'b011, 8, 0, 1'b0, 32'h0};

        repeat (3) cyc();
        chk("rst_cmd", 64'({cmd_we, cmd_adr, cmd_len, cmd_bte}), 64'(0));
        chk("rst_wdat", 64'({wdat, wdat_sel}), 64'(0));
        sdram_rst = 1'b0;

        // all ports empty: nothing moves, stray read beats are ignored
        for (int i = 0; i < 20; i++) begin
            rdat_valid = 1'(i % 2);
            cyc();
            chk("idle_quiet", 64'({fifo_rd, ingress_wr, cmd_valid, wdat_valid, busy}), 64'(0));
        end
        rdat_valid = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // round robin: leave pointer at port 2, then load 0,1,2,0 at once
        v = '{2, 1'b0, 30'h777, 2'b00, 3'b000, 1, 0, 1'b0, 32'h0};
        run_txn(v);
        v = '{0, 1'b0, 30'h1000, 2'b00, 3'b000, 1, 0, 1'b0, 32'h0};
        load_txn(v);
        v = '{1, 1'b0, 30'h1001, 2'b00, 3'b000, 1, 0, 1'b0, 32'h0};
        load_txn(v);
        v = '{2, 1'b0, 30'h1002, 2'b00, 3'b000, 1, 0, 1'b0, 32'h0};
        load_txn(v);
        v = '{0, 1'b0, 30'h1003, 2'b00, 3'b000, 1, 0, 1'b0, 32'h0};
        load_txn(v);
        for (int t = 0; t < 4; t++) begin
            wait_cmd();
            cmd_ready = 1'b1;
            cyc();
            cmd_ready = 1'b0;
            rdat_valid = 1'b1;
            cyc();
            rdat_valid = 1'b0;
        end
        wait_idle();
        check_drained();

        // wrap4 write; egress goes empty after the second data pop
        v = '{2, 1'b1, 30'h2220, 2'b01, 3'b010, 4, 0, 1'b1, 32'hA0000000};
        load_txn(v);
        wait_cmd();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
        base = pops_seen;
        beats_seen = 0;
        forced = 1'b0;
        for (int n = 0; n < 400 && busy; n++) begin
            wdat_ready = 1'($urandom_range(0, 1));
            cyc();
            if (!forced && pops_seen == base + 2) begin
                forced = 1'b1;
                force_empty[2] = 1'b1;
                refresh();
                hold = pops_seen;
                repeat (6) begin
                    wdat_ready = 1'($urandom_range(0, 1));
                    cyc();
                end
                chk("no_pop_while_empty", 64'(pops_seen), 64'(hold));
                force_empty[2] = 1'b0;
                refresh();
            end
        end
        wdat_ready = 1'b0;
        chk("wrap4_forced", 64'(forced), 64'(1));
        chk("wrap4_beats", 64'(beats_seen), 64'(4));
        wait_idle();
        check_drained();

        // reset in the middle of a 16-beat read after 3 beats
        push_port(1, {30'h3330, 1'b0, 2'b11, 3'b010});
        exp_rd.push_back(oh(1));
        exp_cmd.push_back({1'b0, 30'h3330, 5'd16, 2'b11});
        repeat (3) exp_ing.push_back(oh(1));
        refresh();
        wait_cmd();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
        repeat (3) begin
            rdat_valid = 1'b1;
            cyc();
        end
        sdram_rst = 1'b1;
        cyc();
        chk("abort_ctrl", 64'({fifo_rd, ingress_wr, cmd_valid, wdat_valid, busy}), 64'(0));
        chk("abort_cmd", 64'({cmd_we, cmd_adr, cmd_len, cmd_bte}), 64'(0));
        chk("abort_wdat", 64'({wdat, wdat_sel}), 64'(0));
        sdram_rst = 1'b0;
        hold = ing_seen;
        repeat (10) cyc();
        rdat_valid = 1'b0;
        chk("no_ingress_after_rst", 64'(ing_seen), 64'(hold));
        chk("idle_after_rst", 64'(busy), 64'(0));
        check_drained();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
